// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: redirect input, instruction-memory req/ack channel and decode output.
// Memory channel: once imemReq rises, imemAddr is held and imemReq stays high until imemAck; a transfer completes on imemReq && imemAck.
interface instr_fetch_unit_if;
    logic        redirectValid;
    logic [31:0] redirectTarget;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic        instrValid;
    logic [31:0] instrOut;
    logic [31:0] instrPC;
    logic        decodeReady;

    // Fetch unit side
    modport master (
        input  redirectValid, redirectTarget, imemAck, imemData, decodeReady,
        output imemReq, imemAddr, instrValid, instrOut, instrPC
    );

    // Memory / decode / next-PC side
    modport slave (
        output redirectValid, redirectTarget, imemAck, imemData, decodeReady,
        input  imemReq, imemAddr, instrValid, instrOut, instrPC
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Owns the PC and fetches one instruction at a time from imem; squashes wrong-path
// fetches on redirect while keeping the outstanding memory request intact.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic                        clk,
    input  logic                        rst,
    instr_fetch_unit_if.master          fetch_if,
    output logic [1:0]                  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        valid_q, valid_d;
    logic [31:0] target_w;

    assign target_w = fetch_if.redirectTarget & 32'hFFFF_FFFC;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC & 32'hFFFF_FFFC;
            pend_q     <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;

        case (state_q)
            S_IDLE: begin
                if (fetch_if.redirectValid) pc_d = target_w;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (fetch_if.imemAck) begin
                    if (fetch_if.redirectValid) begin
                        pc_d = target_w;
                    end else begin
                        instr_d    = fetch_if.imemData;
                        instr_pc_d = pc_q;
                        pc_d       = pc_q + 32'd4;
                        valid_d    = 1'b1;
                        state_d    = S_HOLD;
                    end
                end else if (fetch_if.redirectValid) begin
                    // Request must complete at the old address; remember where to go next.
                    pend_d  = target_w;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fetch_if.redirectValid) pend_d = target_w;
                if (fetch_if.imemAck) begin
                    pc_d    = fetch_if.redirectValid ? target_w : pend_q;
                    state_d = S_FETCH;
                end
            end
            S_HOLD: begin
                if (fetch_if.redirectValid) begin
                    pc_d    = target_w;
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                end else if (fetch_if.decodeReady) begin
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign fetch_if.imemReq    = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign fetch_if.imemAddr   = pc_q;
    assign fetch_if.instrValid = valid_q;
    assign fetch_if.instrOut   = instr_q;
    assign fetch_if.instrPC    = instr_pc_q;
    assign dbg_state_o         = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, back-pressure, redirects in
// HOLD/FETCH/DRAIN, same-cycle ack+redirect, PC wrap and mid-operation reset.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [1:0]  ST_IDLE = 2'd0, ST_FETCH = 2'd1, ST_DRAIN = 2'd2, ST_HOLD = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  dbg_state;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_if    (bus.master),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic [31:0] rt, input logic ack,
                         input logic [31:0] data, input logic dr);
        bus.redirectValid  = rv;
        bus.redirectTarget = rt;
        bus.imemAck        = ack;
        bus.imemData       = data;
        bus.decodeReady    = dr;
    endtask

    task automatic chk_fetch(input string tag, input logic [31:0] addr);
        chk({tag, "_req"},   {31'd0, bus.imemReq}, 32'd1);
        chk({tag, "_addr"},  bus.imemAddr, addr);
        chk({tag, "_valid"}, {31'd0, bus.instrValid}, 32'd0);
    endtask

    task automatic chk_hold(input string tag, input logic [31:0] instr, input logic [31:0] pc);
        chk({tag, "_req"},   {31'd0, bus.imemReq}, 32'd0);
        chk({tag, "_valid"}, {31'd0, bus.instrValid}, 32'd1);
        chk({tag, "_instr"}, bus.instrOut, instr);
        chk({tag, "_pc"},    bus.instrPC, pc);
    endtask

    // Scoreboard: every decode acceptance must match the next expected instrPC.
    always @(negedge clk) begin
        if (!rst && bus.instrValid === 1'b1 && bus.decodeReady === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL accept_unexpected: got=%h exp=none", bus.instrPC);
            end else begin
                chk("accept_pc", bus.instrPC, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        // Reset state
        chk("rst_req",   {31'd0, bus.imemReq}, 32'd0);
        chk("rst_addr",  bus.imemAddr, RST_PC);
        chk("rst_valid", {31'd0, bus.instrValid}, 32'd0);
        chk("rst_instr", bus.instrOut, 32'h0);
        chk("rst_ipc",   bus.instrPC, 32'h0);
        rst = 1'b0;
        chk("idle_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});

        // Sequential fetch, same-cycle ack
        tick();
        chk_fetch("f0", 32'h0040_0000);
        exp_q.push_back(32'h0040_0000);
        drive(1'b0, 32'h0, 1'b1, 32'h1111_1111, 1'b1);
        tick();
        chk_hold("h0", 32'h1111_1111, 32'h0040_0000);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        tick();
        chk_fetch("f1", 32'h0040_0004);
        drive(1'b0, 32'h0, 1'b1, 32'h2222_2222, 1'b1);

        // Back-pressure for 5 cycles
        tick();
        for (int i = 0; i < 5; i++) begin
            chk_hold("bp", 32'h2222_2222, 32'h0040_0004);
            chk("bp_pc_hold", bus.imemAddr, 32'h0040_0008);
            drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            tick();
        end
        chk_hold("bp_end", 32'h2222_2222, 32'h0040_0004);
        exp_q.push_back(32'h0040_0004);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        tick();
        chk_fetch("f2", 32'h0040_0008);
        drive(1'b0, 32'h0, 1'b1, 32'h3333_3333, 1'b1);

        // Redirect in HOLD with decodeReady=0: instruction squashed
        tick();
        chk_hold("h2", 32'h3333_3333, 32'h0040_0008);
        drive(1'b1, 32'h0040_0100, 1'b0, 32'h0, 1'b0);
        tick();
        chk_fetch("redir_hold", 32'h0040_0100);

        // Redirect while waiting, then a second one during DRAIN
        drive(1'b1, 32'h0040_0200, 1'b0, 32'h0, 1'b1);
        tick();
        chk_fetch("drain0", 32'h0040_0100);
        chk("drain0_state", {30'd0, dbg_state}, {30'd0, ST_DRAIN});
        drive(1'b1, 32'h0040_0300, 1'b0, 32'h0, 1'b1);
        tick();
        chk_fetch("drain1", 32'h0040_0100);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        tick();
        chk_fetch("drain2", 32'h0040_0100);
        drive(1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        tick();
        chk_fetch("after_drain", 32'h0040_0300);
        chk("after_drain_state", {30'd0, dbg_state}, {30'd0, ST_FETCH});

        // Same-cycle ack and redirect with unaligned target
        drive(1'b1, 32'h0040_0043, 1'b1, 32'h4444_4444, 1'b1);
        tick();
        chk_fetch("ack_redir", 32'h0040_0040);
        exp_q.push_back(32'h0040_0040);
        drive(1'b0, 32'h0, 1'b1, 32'h5555_5555, 1'b1);
        tick();
        chk_hold("h3", 32'h5555_5555, 32'h0040_0040);

        // Redirect in HOLD with decodeReady=1: transfer still counts
        exp_q.push_back(32'hFFFF_FFFC);
        drive(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1);
        tick();
        chk_fetch("wrap_f", 32'hFFFF_FFFC);
        drive(1'b0, 32'h0, 1'b1, 32'h6666_6666, 1'b1);
        tick();
        chk_hold("wrap_h", 32'h6666_6666, 32'hFFFF_FFFC);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        tick();
        chk_fetch("wrap_next", 32'h0000_0000);

        // Reset during DRAIN
        drive(1'b1, 32'h0040_0500, 1'b0, 32'h0, 1'b1);
        tick();
        chk("drain_r_state", {30'd0, dbg_state}, {30'd0, ST_DRAIN});
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        chk("mrst_req",   {31'd0, bus.imemReq}, 32'd0);
        chk("mrst_valid", {31'd0, bus.instrValid}, 32'd0);
        chk("mrst_addr",  bus.imemAddr, RST_PC);
        rst = 1'b0;
        tick();
        chk_fetch("restart", RST_PC);
        exp_q.push_back(RST_PC);
        drive(1'b0, 32'h0, 1'b1, 32'h7777_7777, 1'b1);
        tick();
        chk_hold("h_restart", 32'h7777_7777, RST_PC);
        chk("restart_state", {30'd0, dbg_state}, {30'd0, ST_HOLD});
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        tick();
        chk("exp_q_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Owns the architectural PC register and fetches instructions from instruction memory over a req/ack handshake.
- Sits upstream of decode and consumes the redirect (taken branch / jump target) produced by the next-PC selection logic.
- Holds at most one memory request outstanding.
- Squashes wrong-path fetches on redirect without violating the memory protocol.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset (word aligned).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- redirectValid  input  1  taken branch/jump resolved this cycle.
- redirectTarget  input  32  new PC when redirectValid=1; bits [1:0] ignored (treated as 00).
- imemReq  output  1  fetch request to instruction memory.
- imemAddr  output  32  fetch address; bits [1:0] always 00.
- imemAck  input  1  memory returns data this cycle; may assert in the same cycle as imemReq.
- imemData  input  32  instruction word, valid when imemAck=1.
- instrValid  output  1  instrOut/instrPC hold a valid fetched instruction.
- instrOut  output  32  fetched instruction.
- instrPC  output  32  address of instrOut.
- decodeReady  input  1  decode accepts instruction when instrValid && decodeReady.

Behaviour:
- Reset (rst=1 at edge):
  - State -> IDLE; pc=RESET_PC; pendTarget=0.
  - imemReq=0, imemAddr=RESET_PC, instrValid=0, instrOut=0, instrPC=0.
  - Reset asserted mid-operation abandons any request; memory must tolerate an abandoned request on reset only.
- State IDLE:
  - imemReq=0.
  - Next cycle -> FETCH, unconditionally unless redirectValid, in which case pc<=target first and then -> FETCH.
- State FETCH:
  - imemReq=1, imemAddr=pc.
  - Protocol rule: once imemReq is high, imemAddr must stay stable and imemReq must stay high until imemAck.
  - imemAck=1 && redirectValid=0: instrOut<=imemData, instrPC<=pc, pc<=pc+4 (32-bit wrap, 32'hFFFF_FFFC+4=0), instrValid<=1, -> HOLD.
  - imemAck=1 && redirectValid=1: data discarded, pc<=redirectTarget&~3, stay FETCH; imemAddr shows the new pc next cycle.
  - imemAck=0 && redirectValid=1: pendTarget<=redirectTarget&~3, -> DRAIN.
  - imemAck=0 && redirectValid=0: stay FETCH.
- State DRAIN:
  - imemReq=1, imemAddr=old pc (unchanged).
  - redirectValid updates pendTarget; the last redirect wins.
  - On imemAck: data discarded, pc<=pendTarget (or redirectTarget if redirectValid in the same cycle), -> FETCH.
  - instrValid=0 throughout.
- State HOLD:
  - imemReq=0; instrValid=1; outputs stable until accepted.
  - decodeReady=1 && redirectValid=0: transfer occurs, instrValid<=0, -> FETCH with pc (already +4).
  - redirectValid=1, regardless of decodeReady: pc<=redirectTarget&~3, instrValid<=0, -> FETCH.
    - If decodeReady=1 in that cycle, the transfer still counts.
    - If decodeReady=0, the held instruction is squashed.
  - Otherwise stay HOLD.
- Throughput: with single-cycle ack and decodeReady=1, one instruction per 2 cycles.
- Latency: first imemReq in the second cycle after rst deasserts.
- instrValid never asserts for data fetched on a squashed path.

Test Plan:
- Reset then sequential fetch, imemAck echoed same cycle, decodeReady=1:
  - imemAddr 0x00400000, 0x00400004, 0x00400008 on successive FETCH cycles.
  - instrPC matches each address; instrValid pulses every 2nd cycle.
- Back-pressure: decodeReady=0 for 5 cycles in HOLD -> instrValid, instrOut, instrPC stable; imemReq=0; no pc advance.
- Redirect during HOLD to 0x00400100 with decodeReady=0 -> instrValid drops; next imemAddr=0x00400100; squashed instruction never accepted.
- Redirect while FETCH waiting (ack delayed 3 cycles), target 0x00400200, then a second redirect 0x00400300 during DRAIN:
  - imemAddr stays at the old pc until ack; that data is discarded.
  - Next request is to 0x00400300.
- Same-cycle imemAck and redirect to 0x00400043 -> data dropped; next imemAddr=0x00400040; instrValid stays 0.
- Wrap and reset mid-operation:
  - pc=0xFFFFFFFC fetched -> next imemAddr=0x00000000.
  - Assert rst during DRAIN -> next cycle imemReq=0, instrValid=0; restart at RESET_PC.
